// File: rtl/colour_centroid_tracker.sv
// Colour-window centroid tracker: accumulates the coordinates of matching RGB444 pixels
// per camera frame and divides them out sequentially at each frame end.
module colour_centroid_tracker #(
  parameter int         WIDTH      = 320,
  parameter int         HEIGHT     = 240,
  parameter logic [3:0] R_MIN      = 4'd10,
  parameter logic [3:0] G_MAX      = 4'd5,
  parameter logic [3:0] B_MAX      = 4'd5,
  parameter int         MIN_PIXELS = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_sync,
  input  logic        pix_we,
  input  logic [11:0] pix_data,
  output logic [8:0]  centroid_x,
  output logic [7:0]  centroid_y,
  output logic [16:0] match_count,
  output logic        found,
  output logic        result_valid,
  output logic        overrun,
  output logic        busy
);

  localparam logic [8:0]  X_LAST    = 9'(WIDTH - 1);
  localparam logic [7:0]  Y_END     = 8'(HEIGHT);
  localparam logic [16:0] MIN_CNT   = 17'(MIN_PIXELS);
  localparam logic [4:0]  LAST_STEP = 5'd25;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] DIVIDE = 1'b1;

  logic        fs_q;
  logic [8:0]  x_cnt;
  logic [7:0]  y_cnt;
  logic [16:0] cnt;
  logic [24:0] sum_x;
  logic [24:0] sum_y;

  logic [0:0]  state;
  logic [4:0]  step;
  logic [16:0] div_cnt;
  logic [24:0] quo_x;
  logic [24:0] quo_y;
  logic [16:0] rem_x;
  logic [16:0] rem_y;

  logic        frame_end;
  logic        in_frame;
  logic        pix_match;
  logic [17:0] divisor_ext;
  logic [17:0] shift_x;
  logic [17:0] shift_y;
  logic        take_x;
  logic        take_y;
  logic        found_next;
  logic        use_quotient;

  assign frame_end = frame_sync & ~fs_q;
  assign in_frame  = pix_we & ~frame_sync & (y_cnt < Y_END);
  assign pix_match = in_frame & (pix_data[11:8] >= R_MIN) &
                     (pix_data[7:4] <= G_MAX) & (pix_data[3:0] <= B_MAX);

  // One restoring step per cycle: the dividend shifts out of the quotient register MSB first
  // while the new quotient bit shifts in at the bottom.
  assign divisor_ext = {1'b0, div_cnt};
  assign shift_x     = {rem_x, quo_x[24]};
  assign shift_y     = {rem_y, quo_y[24]};
  assign take_x      = shift_x >= divisor_ext;
  assign take_y      = shift_y >= divisor_ext;

  assign found_next   = div_cnt >= MIN_CNT;
  assign use_quotient = found_next && (div_cnt != 17'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fs_q  <= 1'b0;
      x_cnt <= '0;
      y_cnt <= '0;
    end else begin
      fs_q <= frame_sync;
      if (frame_sync) begin
        x_cnt <= '0;
        y_cnt <= '0;
      end else if (in_frame) begin
        if (x_cnt == X_LAST) begin
          x_cnt <= '0;
          y_cnt <= y_cnt + 8'd1;
        end else begin
          x_cnt <= x_cnt + 9'd1;
        end
      end
    end
  end

  // Live accumulators restart at every frame end, whether or not the divider took the frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      sum_x <= '0;
      sum_y <= '0;
    end else if (frame_end) begin
      cnt   <= '0;
      sum_x <= '0;
      sum_y <= '0;
    end else if (pix_match) begin
      cnt   <= cnt + 17'd1;
      sum_x <= sum_x + {16'd0, x_cnt};
      sum_y <= sum_y + {17'd0, y_cnt};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      step         <= '0;
      div_cnt      <= '0;
      quo_x        <= '0;
      quo_y        <= '0;
      rem_x        <= '0;
      rem_y        <= '0;
      centroid_x   <= '0;
      centroid_y   <= '0;
      match_count  <= '0;
      found        <= 1'b0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_end) begin
            div_cnt <= cnt;
            quo_x   <= sum_x;
            quo_y   <= sum_y;
            rem_x   <= '0;
            rem_y   <= '0;
            step    <= '0;
            busy    <= 1'b1;
            state   <= DIVIDE;
          end
        end
        DIVIDE: begin
          if (frame_end) begin
            overrun <= 1'b1;
          end
          if (step == LAST_STEP) begin
            match_count  <= div_cnt;
            found        <= found_next;
            centroid_x   <= use_quotient ? quo_x[8:0] : 9'd0;
            centroid_y   <= use_quotient ? quo_y[7:0] : 8'd0;
            result_valid <= 1'b1;
            busy         <= 1'b0;
            state        <= IDLE;
          end else begin
            step  <= step + 5'd1;
            quo_x <= {quo_x[23:0], take_x};
            quo_y <= {quo_y[23:0], take_y};
            rem_x <= take_x ? 17'(shift_x - divisor_ext) : shift_x[16:0];
            rem_y <= take_y ? 17'(shift_y - divisor_ext) : shift_y[16:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_colour_centroid_tracker.sv
// Scoreboard bench for colour_centroid_tracker: two instances (default threshold and MIN_PIXELS=1)
// share framing but see independent pixel streams; a frame-level model predicts each result.
module tb_colour_centroid_tracker;

  localparam int W = 320;
  localparam int H = 240;

  typedef struct {
    longint cnt;
    longint cx;
    longint cy;
    bit     found;
    longint due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        frame_sync;
  logic        pix_we;
  logic [11:0] pix_data0;
  logic [11:0] pix_data1;

  logic [8:0]  cx0, cx1;
  logic [7:0]  cy0, cy1;
  logic [16:0] mc0, mc1;
  logic        found0, found1, rv0, rv1, ovr0, ovr1, busy0, busy1;

  longint cyc = 0;
  int     checks = 0;
  int     failures = 0;
  int     busy_fail_prints = 0;

  exp_t   q0[$];
  exp_t   q1[$];
  int     idx;
  longint acc_cnt[2];
  longint acc_sx[2];
  longint acc_sy[2];
  longint busy_end;
  longint cur_e;
  bit     exp_ovr;

  colour_centroid_tracker dut0 (
    .clk(clk), .reset_n(reset_n), .frame_sync(frame_sync), .pix_we(pix_we),
    .pix_data(pix_data0), .centroid_x(cx0), .centroid_y(cy0), .match_count(mc0),
    .found(found0), .result_valid(rv0), .overrun(ovr0), .busy(busy0)
  );

  colour_centroid_tracker #(.MIN_PIXELS(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .frame_sync(frame_sync), .pix_we(pix_we),
    .pix_data(pix_data1), .centroid_x(cx1), .centroid_y(cy1), .match_count(mc1),
    .found(found1), .result_valid(rv1), .overrun(ovr1), .busy(busy1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic bit is_match(input logic [11:0] p);
    return (p[11:8] >= 4'd10) && (p[7:4] <= 4'd5) && (p[3:0] <= 4'd5);
  endfunction

  function automatic int min_for(input int k);
    return (k == 0) ? 64 : 1;
  endfunction

  function automatic exp_t make_exp(input int k, input longint due);
    exp_t e;
    e.cnt   = acc_cnt[k];
    e.found = acc_cnt[k] >= min_for(k);
    e.cx    = (e.found && acc_cnt[k] > 0) ? acc_sx[k] / acc_cnt[k] : 0;
    e.cy    = (e.found && acc_cnt[k] > 0) ? acc_sy[k] / acc_cnt[k] : 0;
    e.due   = due;
    return e;
  endfunction

  task automatic clear_acc();
    for (int k = 0; k < 2; k++) begin
      acc_cnt[k] = 0;
      acc_sx[k]  = 0;
      acc_sy[k]  = 0;
    end
    idx = 0;
  endtask

  // The n-th accepted strobe of a frame sits at column n%W, row n/W; past W*H nothing counts.
  task automatic model_strobe(input logic [11:0] d0, input logic [11:0] d1);
    if (idx < W * H) begin
      if (is_match(d0)) begin
        acc_cnt[0]++; acc_sx[0] += idx % W; acc_sy[0] += idx / W;
      end
      if (is_match(d1)) begin
        acc_cnt[1]++; acc_sx[1] += idx % W; acc_sy[1] += idx / W;
      end
      idx++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic we, input logic [11:0] d0, input logic [11:0] d1);
    pix_we    = we;
    pix_data0 = d0;
    pix_data1 = d1;
    if (we && !frame_sync) model_strobe(d0, d1);
    tick();
  endtask

  function automatic logic [11:0] rand_pix(input int pct);
    logic [11:0] p;
    if ($urandom_range(0, 99) < pct)
      p = {4'($urandom_range(10, 15)), 4'($urandom_range(0, 5)), 4'($urandom_range(0, 5))};
    else if ($urandom_range(0, 1) == 0)
      p = {4'($urandom_range(8, 12)), 4'($urandom_range(4, 7)), 4'($urandom_range(4, 7))};
    else
      p = 12'($urandom);
    return p;
  endfunction

  task automatic pixels(input int n, input int pct);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 4) == 0) apply_stimulus(1'b0, rand_pix(pct), rand_pix(pct));
      apply_stimulus(1'b1, rand_pix(pct), rand_pix(pct));
    end
    pix_we = 1'b0;
  endtask

  task automatic frame_end(input int blank);
    longint edge_c;
    frame_sync = 1'b1;
    pix_we     = 1'b0;
    edge_c     = cyc + 1;
    if (edge_c > busy_end) begin
      q0.push_back(make_exp(0, edge_c + 26));
      q1.push_back(make_exp(1, edge_c + 26));
      cur_e    = edge_c;
      busy_end = edge_c + 26;
    end else begin
      exp_ovr = 1'b1;
    end
    clear_acc();
    tick();
    for (int i = 1; i < blank; i++) begin
      pix_we    = 1'($urandom);
      pix_data0 = 12'hF00;
      pix_data1 = 12'hF00;
      tick();
    end
    frame_sync = 1'b0;
    pix_we     = 1'b0;
    tick();
  endtask

  task automatic wait_idle();
    while (cyc + 1 <= busy_end) tick();
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    frame_sync = 1'b0;
    pix_we     = 1'b0;
    #1;
    check_output("rst_dut0_cx", cx0, 0);      check_output("rst_dut1_cx", cx1, 0);
    check_output("rst_dut0_cy", cy0, 0);      check_output("rst_dut1_cy", cy1, 0);
    check_output("rst_dut0_count", mc0, 0);   check_output("rst_dut1_count", mc1, 0);
    check_output("rst_dut0_found", found0, 0); check_output("rst_dut1_found", found1, 0);
    check_output("rst_dut0_valid", rv0, 0);   check_output("rst_dut1_valid", rv1, 0);
    check_output("rst_dut0_overrun", ovr0, 0); check_output("rst_dut1_overrun", ovr1, 0);
    check_output("rst_dut0_busy", busy0, 0);  check_output("rst_dut1_busy", busy1, 0);
    q0.delete();
    q1.delete();
    clear_acc();
    busy_end = -1;
    cur_e    = -1000;
    exp_ovr  = 1'b0;
    tick(); tick(); tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic check_result(input int k, input logic [8:0] cx, input logic [7:0] cy,
                              input logic [16:0] mc, input logic f, input logic ov,
                              input logic bz);
    exp_t e;
    bit   have;
    have = 1'b0;
    if (k == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
    if (k == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
    if (!have) begin
      check_output($sformatf("dut%0d_unexpected_result", k), 1, 0);
    end else begin
      check_output($sformatf("dut%0d_known", k), $isunknown({cx, cy, mc, f, ov, bz}), 0);
      check_output($sformatf("dut%0d_timing", k), cyc, e.due);
      check_output($sformatf("dut%0d_count", k), mc, e.cnt);
      check_output($sformatf("dut%0d_found", k), f, e.found);
      check_output($sformatf("dut%0d_cx", k), cx, e.cx);
      check_output($sformatf("dut%0d_cy", k), cy, e.cy);
      check_output($sformatf("dut%0d_overrun", k), ov, exp_ovr);
      check_output($sformatf("dut%0d_busy_done", k), bz, 0);
    end
  endtask

  task automatic check_busy(input int k, input logic bz);
    bit want;
    want = (cyc >= cur_e) && (cyc < cur_e + 26);
    checks++;
    if (bz !== want) begin
      failures++;
      if (busy_fail_prints < 5) begin
        busy_fail_prints++;
        $display("[TB] FAIL dut%0d_busy actual=%0b expected=%0b (cycle %0d)", k, bz, want, cyc);
      end
    end
  endtask

  // Monitor: independent of stimulus, consumes expectations whenever a DUT reports a result.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (rv0 === 1'b1) check_result(0, cx0, cy0, mc0, found0, ovr0, busy0);
      if (rv1 === 1'b1) check_result(1, cx1, cy1, mc1, found1, ovr1, busy1);
      if (q0.size() > 0 && q0[0].due < cyc) begin
        check_output("dut0_missing_result", cyc, q0[0].due);
        void'(q0.pop_front());
      end
      if (q1.size() > 0 && q1[0].due < cyc) begin
        check_output("dut1_missing_result", cyc, q1[0].due);
        void'(q1.pop_front());
      end
      check_busy(0, busy0);
      check_busy(1, busy1);
    end
  end

  initial begin
    logic [11:0] d0, d1;
    int          xx, yy;
    reset_n    = 1'b0;
    frame_sync = 1'b0;
    pix_we     = 1'b0;
    pix_data0  = '0;
    pix_data1  = '0;
    clear_acc();
    busy_end = -1;
    cur_e    = -1000;
    exp_ovr  = 1'b0;
    tick();
    do_reset();

    // Empty frame straight after reset
    frame_end(4);
    wait_idle();

    for (int f = 0; f < 4; f++) begin
      pixels($urandom_range(100, 250), (f == 0) ? 0 : $urandom_range(20, 80));
      frame_end($urandom_range(3, 8));
      wait_idle();
    end

    // 40 matches: under the default minimum, enough for the second instance
    for (int i = 0; i < 200; i++)
      apply_stimulus(1'b1, (i < 40) ? 12'hF00 : 12'h0F0, (i < 40) ? 12'hF00 : 12'h0F0);
    frame_end(3);
    wait_idle();

    // Threshold edges: A55 counts, 955 does not
    for (int i = 0; i < 160; i++) begin
      d0 = (i % 2 == 0) ? 12'hA55 : 12'h955;
      d1 = (i % 3 == 0) ? 12'hA55 : 12'h955;
      apply_stimulus(1'b1, d0, d1);
    end
    frame_end(3);
    wait_idle();

    // Second frame end ten cycles after the first is dropped
    pixels(100, 60);
    frame_end(3);
    for (int i = 0; i < 6; i++) apply_stimulus(1'b1, rand_pix(60), rand_pix(60));
    frame_end(3);
    pixels(30, 60);
    wait_idle();
    check_output("dut0_overrun_sticky", ovr0, exp_ovr);
    check_output("dut1_overrun_sticky", ovr1, exp_ovr);
    frame_end(3);
    wait_idle();

    // Reset while the divider is busy, then a partial frame seen only after reset
    pixels(80, 60);
    frame_end(3);
    pixels(3, 60);
    do_reset();
    pixels(50, 60);
    frame_end(3);
    wait_idle();

    // Full frame plus overlong tail: block on dut0, bottom-right corner on dut1
    for (int i = 0; i < W * H + 20; i++) begin
      xx = i % W;
      yy = i / W;
      if (i >= W * H) begin
        d0 = 12'hF00;
        d1 = 12'hF00;
      end else begin
        d0 = (xx >= 100 && xx <= 109 && yy >= 50 && yy <= 59) ? 12'hF00 : 12'h0F0;
        d1 = (i == W * H - 1) ? 12'hF00 : 12'h0F0;
      end
      apply_stimulus(1'b1, d0, d1);
    end
    frame_end(3);
    wait_idle();

    repeat (40) tick();
    check_output("dut0_pending_results", q0.size(), 0);
    check_output("dut1_pending_results", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
